// File: rtl/aes_inv_key_store.sv
// rtl/aes_inv_key_store.sv - AES-128/192/256 key expansion and round-key store for the inverse cipher
// Define AES_EQINV_EN to return InvMixColumns-transformed keys for rounds 1..NR-1 (equivalent inverse cipher).

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = x;
        for (int b = 0; b < 8; b++) begin
            if (y[b]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    always_comb begin
        sq  = a_i;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_inv_key_store #(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kld,
    input  logic [32*NK-1:0]  key,
    output logic              busy,
    output logic              key_rdy,
    input  logic              rk_rd,
    input  logic [3:0]        rk_idx,
    output logic              rk_vld,
    output logic              rk_err,
    output logic [127:0]      rk
);
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [3:0] NR_W   = 4'(NR);
    localparam logic [2:0] PH_MAX = 3'(NK - 1);
    localparam logic [2:0] PH_SUB = 3'd4;

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
            $fatal(1, "aes_inv_key_store: NK must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [2:0]   ph_q, ph_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] rk_q, rk_d;
    logic         rk_vld_q, rk_vld_d;
    logic         rk_err_q, rk_err_d;
    logic [31:0]  w_q [0:NW-1];

    logic [31:0]  w_prev, w_old, sb_in, sb_out, t_word, w_new;

    assign w_prev = w_q[cnt_q - 6'd1];
    assign w_old  = w_q[cnt_q - NK_W];
    // ph_q tracks i mod NK so the NK=6 case needs no divider.
    assign sb_in  = (ph_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .a_i (sb_in[8*b +: 8]),
                .y_o (sb_out[8*b +: 8])
            );
        end
    endgenerate

    always_comb begin
        t_word = w_prev;
        if (ph_q == 3'd0) begin
            t_word = sb_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && ph_q == PH_SUB) begin
            t_word = sb_out;
        end
    end

    assign w_new = w_old ^ t_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        rcon_d  = rcon_q;
        if (kld) begin
            state_d = S_EXPAND;
            cnt_d   = NK_W;
            ph_d    = 3'd0;
            rcon_d  = 8'h01;
        end else begin
            case (state_q)
                S_EXPAND: begin
                    cnt_d = cnt_q + 6'd1;
                    ph_d  = (ph_q == PH_MAX) ? 3'd0 : ph_q + 3'd1;
                    if (ph_q == 3'd0) rcon_d = xtime(rcon_q);
                    if (cnt_q == LAST_W) state_d = S_READY;
                end
                default: ;
            endcase
        end
    end

    logic         rd_ok;
    logic [5:0]   base;
    logic [127:0] rk_raw, rk_sel;

    assign rd_ok  = !kld && (state_q == S_READY) && (rk_idx <= NR_W);
    assign base   = {rk_idx, 2'b00};
    assign rk_raw = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};

`ifdef AES_EQINV_EN
    function automatic logic [7:0] gmul_c(input logic [7:0] v, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(v);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? v : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul_c(a0, 4'he) ^ gmul_c(a1, 4'hb) ^ gmul_c(a2, 4'hd) ^ gmul_c(a3, 4'h9),
                gmul_c(a0, 4'h9) ^ gmul_c(a1, 4'he) ^ gmul_c(a2, 4'hb) ^ gmul_c(a3, 4'hd),
                gmul_c(a0, 4'hd) ^ gmul_c(a1, 4'h9) ^ gmul_c(a2, 4'he) ^ gmul_c(a3, 4'hb),
                gmul_c(a0, 4'hb) ^ gmul_c(a1, 4'hd) ^ gmul_c(a2, 4'h9) ^ gmul_c(a3, 4'he)};
    endfunction

    // First and last round keys are applied raw by the equivalent inverse cipher.
    always_comb begin
        rk_sel = rk_raw;
        if (rk_idx != 4'd0 && rk_idx != NR_W) begin
            for (int c = 0; c < 4; c++) begin
                rk_sel[32*c +: 32] = inv_mix_col(rk_raw[32*c +: 32]);
            end
        end
    end
`else
    assign rk_sel = rk_raw;
`endif

    always_comb begin
        rk_d     = rk_q;
        rk_vld_d = 1'b0;
        rk_err_d = 1'b0;
        if (rk_rd) begin
            if (rd_ok) begin
                rk_d     = rk_sel;
                rk_vld_d = 1'b1;
            end else begin
                rk_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            ph_q     <= 3'd0;
            rcon_q   <= 8'h01;
            rk_q     <= '0;
            rk_vld_q <= 1'b0;
            rk_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            rcon_q   <= rcon_d;
            rk_q     <= rk_d;
            rk_vld_q <= rk_vld_d;
            rk_err_q <= rk_err_d;
        end
    end

    // The store itself needs no reset: key_rdy gates every read.
    always_ff @(posedge clk) begin
        if (kld) begin
            for (int j = 0; j < NK; j++) begin
                w_q[j] <= key[32*(NK-1-j) +: 32];
            end
        end else if (state_q == S_EXPAND) begin
            w_q[cnt_q] <= w_new;
        end
    end

    assign busy    = (state_q == S_EXPAND);
    assign key_rdy = (state_q == S_READY);
    assign rk_vld  = rk_vld_q;
    assign rk_err  = rk_err_q;
    assign rk      = rk_q;
endmodule

// File: tb/tb_aes_inv_key_store.sv
// tb/tb_aes_inv_key_store.sv - randomized and directed bench for aes_inv_key_store at NK=4/6/8
module tb_aes_inv_key_store;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]   kld_v, rd_v, busy_v, rdy_v, vld_v, err_v;
    logic [255:0] key_v [3];
    logic [3:0]   idx_v [3];
    logic [127:0] rk_v  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NKG = 4 + 2 * g;
        aes_inv_key_store #(.NK(NKG)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .kld     (kld_v[g]),
            .key     (key_v[g][32*NKG-1:0]),
            .busy    (busy_v[g]),
            .key_rdy (rdy_v[g]),
            .rk_rd   (rd_v[g]),
            .rk_idx  (idx_v[g]),
            .rk_vld  (vld_v[g]),
            .rk_err  (err_v[g]),
            .rk      (rk_v[g])
        );
    end

    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K2B  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KFF  = 256'hffffffffffffffffffffffffffffffff;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    int n_checks = 0;
    int n_fails  = 0;
    string gs [3] = '{"g0", "g1", "g2"};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox [256];
    logic [31:0] mw [3][60];

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Walk p over powers of 3 while q tracks the matching inverse.
    function automatic void build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            sbox[p] = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    function automatic void expand(input int g, input logic [255:0] k);
        int nk, nw;
        logic [31:0] t;
        logic [7:0]  rc;
        nk = 4 + 2 * g;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) mw[g][i] = k[32*(nk-1-i) +: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[g][i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            mw[g][i] = mw[g][i-nk] ^ t;
        end
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = v[32*c +: 32];
            o[32*c +: 32] = {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
                             gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
                             gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
                             gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
        end
        return o;
    endfunction

    function automatic logic [127:0] raw_key(input int g, input int r);
        return {mw[g][4*r], mw[g][4*r+1], mw[g][4*r+2], mw[g][4*r+3]};
    endfunction

    function automatic logic [127:0] round_key(input int g, input int r);
        logic [127:0] v;
        v = raw_key(g, r);
`ifdef AES_EQINV_EN
        if (r > 0 && r < 4 + 2 * g + 6) v = inv_mix(v);
`endif
        return v;
    endfunction

    bit         m_busy [3];
    bit         m_rdy  [3];
    int         m_left [3];
    bit         e_vld  [3];
    bit         e_err  [3];
    bit [127:0] e_rk   [3];
    bit         m_pre;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int g = 0; g < 3; g++) begin
                m_busy[g] = 1'b0; m_rdy[g] = 1'b0; m_left[g] = 0;
                e_vld[g] = 1'b0;  e_err[g] = 1'b0; e_rk[g] = '0;
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                m_pre = m_rdy[g];
                e_vld[g] = 1'b0;
                e_err[g] = 1'b0;
                if (rd_v[g]) begin
                    if (kld_v[g] || !m_pre || int'(idx_v[g]) > 4 + 2 * g + 6) begin
                        e_err[g] = 1'b1;
                    end else begin
                        e_vld[g] = 1'b1;
                        e_rk[g]  = round_key(g, int'(idx_v[g]));
                    end
                end
                if (kld_v[g]) begin
                    expand(g, key_v[g]);
                    m_busy[g] = 1'b1;
                    m_rdy[g]  = 1'b0;
                    m_left[g] = 4 * (4 + 2 * g + 7) - (4 + 2 * g);
                end else if (m_busy[g]) begin
                    m_left[g]--;
                    if (m_left[g] == 0) begin
                        m_busy[g] = 1'b0;
                        m_rdy[g]  = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int g = 0; g < 3; g++) begin
                check({"busy_", gs[g]}, 128'(busy_v[g]), 128'(m_busy[g]));
                check({"key_rdy_", gs[g]}, 128'(rdy_v[g]), 128'(m_rdy[g]));
                check({"rk_vld_", gs[g]}, 128'(vld_v[g]), 128'(e_vld[g]));
                check({"rk_err_", gs[g]}, 128'(err_v[g]), 128'(e_err[g]));
                check({"rk_", gs[g]}, rk_v[g], e_rk[g]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input int g, input logic [255:0] k);
        key_v[g] = k;
        kld_v[g] = 1'b1;
        @(negedge clk);
        kld_v[g] = 1'b0;
    endtask

    task automatic count_busy(input int g, input int exp_n, input string name);
        int n;
        n = 0;
        while (busy_v[g] === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({name, "_cycles"}, 128'(n), 128'(exp_n));
        check({name, "_rdy"}, 128'(rdy_v[g]), 128'd1);
    endtask

    task automatic read(input int g, input int idx, input bit with_kld,
                        output logic [127:0] v, output logic vld, output logic err);
        rd_v[g]  = 1'b1;
        idx_v[g] = 4'(idx);
        if (with_kld) kld_v[g] = 1'b1;
        @(negedge clk);
        rd_v[g]  = 1'b0;
        kld_v[g] = 1'b0;
        v   = rk_v[g];
        vld = vld_v[g];
        err = err_v[g];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    logic [127:0] v, prev;
    logic         vld, err;
    int           n_vld;

    initial begin
        build_sbox();
        rst = 1'b0;
        kld_v = '0;
        rd_v  = '0;
        for (int g = 0; g < 3; g++) begin
            key_v[g] = '0;
            idx_v[g] = '0;
        end

        check("model_sbox_53", 128'(sbox[8'h53]), 128'hed);
        expand(0, K128);
        check("model_k128_r10", raw_key(0, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
        expand(0, K2B);
        check("model_k2b_r10", raw_key(0, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        expand(1, K192);
        check("model_k192_r12", raw_key(1, 12), 128'ha4970a331a78dc09c418c271e3a41d5d);
        expand(2, K256);
        check("model_k256_r14", raw_key(2, 14), 128'h24fc79ccbf0979e9371ac23c6d68de36);

        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check({"reset_state_", gs[g]},
                  128'({busy_v[g], rdy_v[g], vld_v[g], err_v[g]}), 128'd0);
            check({"reset_rk_", gs[g]}, rk_v[g], 128'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        read(0, 3, 1'b0, v, vld, err);
        check("early_read_err", 128'({vld, err}), 128'b01);

        load(0, K128);
        count_busy(0, 40, "k128_busy");
        read(0, 10, 1'b0, v, vld, err);
        check("k128_r10_vld", 128'(vld), 128'd1);
        check("k128_r10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        read(0, 0, 1'b0, v, vld, err);
        check("k128_r0", v, K128[127:0]);

        load(0, K2B);
        repeat (4) @(negedge clk);
        load(0, KFF);
        count_busy(0, 40, "abort_busy");
        read(0, 10, 1'b0, v, vld, err);
        check("kff_r10", v, raw_key(0, 10));

        load(0, K2B);
        count_busy(0, 40, "k2b_busy");
        read(0, 10, 1'b0, v, vld, err);
        check("k2b_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        prev = rk_v[0];
        read(0, 5, 1'b1, v, vld, err);
        check("kld_read_err", 128'({vld, err}), 128'b01);
        check("kld_read_hold", v, prev);
        count_busy(0, 40, "kld_read_busy");

        load(0, K128);
        count_busy(0, 40, "k128b_busy");
        n_vld = 0;
        for (int r = 10; r >= 0; r--) begin
            rd_v[0]  = 1'b1;
            idx_v[0] = 4'(r);
            @(negedge clk);
            if (vld_v[0] === 1'b1 && rk_v[0] === round_key(0, r)) n_vld++;
        end
        rd_v[0] = 1'b0;
        check("b2b_pulses", 128'(n_vld), 128'd11);
        read(0, 9, 1'b0, v, vld, err);
`ifdef AES_EQINV_EN
        check("r9_eqinv", v, inv_mix(raw_key(0, 9)));
`else
        check("r9_raw", v, raw_key(0, 9));
`endif

        load(1, K192);
        count_busy(1, 46, "k192_busy");
        read(1, 12, 1'b0, v, vld, err);
        check("k192_r12", v, 128'ha4970a331a78dc09c418c271e3a41d5d);

        load(2, K256);
        count_busy(2, 52, "k256_busy");
        read(2, 14, 1'b0, v, vld, err);
        check("k256_r14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read(2, 15, 1'b0, v, vld, err);
        check("k256_idx15_err", 128'({vld, err}), 128'b01);

        load(0, K128);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_g0", 128'({busy_v[0], rdy_v[0]}), 128'd0);
        check("async_rst_g2", 128'({busy_v[2], rdy_v[2], rk_v[2]}), 130'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load(0, K128);
        count_busy(0, 40, "post_rst_busy");
        read(0, 10, 1'b0, v, vld, err);
        check("post_rst_r10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        for (int cyc = 0; cyc < 1200; cyc++) begin
            for (int g = 0; g < 3; g++) begin
                kld_v[g] = ($urandom_range(0, 99) == 0);
                if (kld_v[g])
                    key_v[g] = {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom};
                rd_v[g]  = $urandom_range(0, 1) == 1;
                idx_v[g] = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        kld_v = '0;
        rd_v  = '0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_store.md
Name: aes_inv_key_store

Overview:
Parametrised AES key-schedule engine and round-key store for the iterative inverse cipher. Supports AES-128, AES-192 and AES-256 through NK. On kld it expands the cipher key one 32-bit word per cycle into an internal store, then serves round keys by index with a registered read port. The inverse-cipher datapath reads keys NR down to 0. Interrupted or repeated key loads restart expansion cleanly.

Parameters:
- NK, default 4: key length in 32-bit words; legal values 4, 6, 8. Any other value is a fatal elaboration error.
- NR (localparam) = NK+6: number of rounds, 10/12/14.
- NW (localparam) = 4*(NR+1): total schedule words, 44/52/60.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- kld, input, 1: key load strobe.
- key, input, 32*NK: cipher key, MSB = first key byte; sampled when kld=1.
- busy, output, 1: expansion in progress.
- key_rdy, output, 1: full schedule valid.
- rk_rd, input, 1: round-key read strobe.
- rk_idx, input, 4: round index, 0..NR.
- rk_vld, output, 1: rk holds read data; single-cycle pulse.
- rk_err, output, 1: rejected read; single-cycle pulse.
- rk, output, 128: round key, word 4r in bits [127:96].

Behaviour:
- Reset (rst=0, async): busy=0, key_rdy=0, rk_vld=0, rk_err=0, rk=0. Word counter cleared. Rcon reset to 8'h01. Store contents are don't-care.
- States: IDLE, EXPAND, READY.
- kld=1 at edge E0, from any state:
  - Words w[0..NK-1] are loaded from key.
  - Counter i is set to NK; Rcon is reset to 01.
  - State moves to EXPAND: busy=1, key_rdy=0.
- EXPAND: one word per edge, w[i] = w[i-NK] ^ t, where:
  - t = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0} when i mod NK = 0. Rcon then advances by GF(2^8) xtime (…80 -> 1b -> 36).
  - t = SubWord(w[i-1]) when NK=8 and i mod NK = 4.
  - Otherwise t = w[i-1].
- Word w[i] is written at edge E0+(i-NK+1). The last word (NW-1) is written at edge E0+NW-NK, i.e. E0+40, E0+46 or E0+52.
- After that edge: state READY, busy=0, key_rdy=1.
- S-box: four existing aes_sbox instances, shared across all words.
- kld during EXPAND or READY aborts and restarts from the new key. key_rdy falls after the kld edge and never shows a partial schedule.
- Read: rk_rd=1 sampled at edge R. After edge R+1 the port returns one of:
  - rk = {w[4k], w[4k+1], w[4k+2], w[4k+3]} with k = rk_idx, and rk_vld=1 for one cycle.
  - rk_err=1 for one cycle, with rk unchanged and rk_vld=0. This happens when key_rdy=0, rk_idx>NR, or kld=1 in the same cycle (kld wins).
- Back-to-back reads, one per cycle, are supported; throughput is 1 key per cycle.
- rk holds its last value between reads.
- Mid-operation reset clears all state immediately; the next kld starts a fresh expansion.

Optional Feature:
- Macro AES_EQINV_EN.
- When defined, reads of rounds 1..NR-1 return InvMixColumns applied to each 32-bit column of the stored key, for the equivalent inverse cipher. Rounds 0 and NR are returned raw. The transform is combinational on the read path, and read latency stays at 1 cycle.
- When undefined, all rounds are returned raw and the InvMixColumns logic is absent.

Test Plan:
- NK=4, kld with key=000102030405060708090a0b0c0d0e0f -> busy=1 for 40 cycles, key_rdy=1 after edge E0+40. Read idx 10 -> rk=13111d7fe3944a17f307a78b4d2b30c5. Read idx 0 -> the key itself.
- NK=4, key=2b7e151628aed2a6abf7158809cf4f3c:
  - kld, then 5 cycles later kld with key=ffff…ff, then complete.
  - key_rdy must stay 0 until 40 edges after the second kld.
  - Read idx 10 must match the schedule of key ffff…ff.
  - Repeat with the first key alone -> idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- NK=6, key=000102…1617 -> key_rdy after 46 cycles; idx 12 = a4970a331a78dc09c418c271e3a41d5d.
- NK=8, key=000102…1e1f -> key_rdy after 52 cycles; idx 14 = 24fc79ccbf0979e9371ac23c6d68de36. Read idx 15 -> rk_err pulse, rk_vld=0.
- Error and reset cases:
  - Read before key_rdy -> rk_err=1.
  - Read in the same cycle as kld -> rk_err=1.
  - Reads idx 10..0 back-to-back -> 11 consecutive rk_vld pulses in order.
  - rst=0 mid-EXPAND -> busy=0, key_rdy=0 immediately, without waiting for a clock edge.
- With AES_EQINV_EN, NK=4, FIPS key 000102…0f: idx 0 and 10 unchanged. idx 9 equals InvMixColumns of the raw round-9 key, compared against the bench reference model.
